// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU scheduler types and defaults.
//   fp32_t     raw IEEE-754 single-precision bit pattern
//   div_tag_t  {valid, requester id} travelling alongside an fdiv operation
// The tag id is sized for the largest supported requester count (8); narrower
// schedulers zero-extend into it and truncate back out.
package fpu_pkg;
  typedef logic [31:0] fp32_t;
  localparam int ID_W_MAX = 3;
  localparam int FDIV_LAT_DEFAULT = 2;
  typedef struct packed {logic v; logic [ID_W_MAX-1:0] id;} div_tag_t;
endpackage

// File: rtl/fdiv.sv
// fdiv: pipelined IEEE-754 single-precision divider, y = x1 / x2.
//   clk     pipeline clock (no reset: the datapath carries no control state)
//   x1, x2  dividend and divisor
//   y       quotient, LAT clock edges after x1/x2 change
// Round-to-nearest-even. Subnormal inputs are treated as zero and underflowing
// results flush to signed zero. Any NaN, 0/0 or inf/inf gives qNaN 0x7fc00000.
module fdiv
  import fpu_pkg::*;
#(
  parameter int LAT = FDIV_LAT_DEFAULT
) (
  input  logic  clk,
  input  fp32_t x1,
  input  fp32_t x2,
  output fp32_t y
);
  logic        s, hi, g, st, nan, inf, zero, ovf, unf;
  logic [7:0]  e1, e2;
  logic [23:0] m1, m2, mant;
  logic [49:0] num;
  logic [26:0] q;
  logic [24:0] mr;
  logic [9:0]  ex;
  fp32_t       res;
  fp32_t       y_d [LAT];
  fp32_t       y_q [LAT];
  always_comb begin
    s = x1[31] ^ x2[31];
    e1 = x1[30:23];
    e2 = x2[30:23];
    m1 = {1'b1, x1[22:0]};
    m2 = {1'b1, x2[22:0]};
    // m1/m2 lies in (0.5, 2), so the 27-bit quotient has its leading one at bit 26 or 25
    num = {m1, 26'd0};
    q = 27'(num / {26'd0, m2});
    st = (50'(q) * {26'd0, m2}) != num;
    hi = q[26];
    mant = hi ? q[26:3] : q[25:2];
    g = hi ? q[2] : q[1];
    st = st | (hi ? |q[1:0] : q[0]);
    mr = {1'b0, mant} + 25'(g & (st | mant[0]));
    // signed 10-bit exponent; a rounding carry into bit 24 bumps it by one
    ex = {2'b0, e1} - {2'b0, e2} + (hi ? 10'd127 : 10'd126) + 10'(mr[24]);
    ovf = !ex[9] && ex >= 10'd255;
    unf = ex[9] || ex == 10'd0;
    nan = (e1 == 8'hff && x1[22:0] != 0) || (e2 == 8'hff && x2[22:0] != 0) ||
          (e1 == 8'h00 && e2 == 8'h00) || (e1 == 8'hff && e2 == 8'hff);
    inf = e1 == 8'hff || e2 == 8'h00;
    zero = e1 == 8'h00 || e2 == 8'hff;
    res = nan ? 32'h7fc00000 :
          inf ? {s, 8'hff, 23'd0} :
          zero ? {s, 31'd0} :
          ovf ? {s, 8'hff, 23'd0} :
          unf ? {s, 31'd0} :
          {s, ex[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    y_d[0] = res;
    for (int i = 1; i < LAT; i++) y_d[i] = y_q[i-1];
  end
  always_ff @(posedge clk) y_q <= y_d;
  assign y = y_q[LAT-1];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        per-requester request bits
//   en         0 forces an empty grant
//   ptr        last granted index; the search starts at ptr+1 and wraps
//   grant      one-hot grant (all zero when nothing is granted)
//   grant_idx  index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int W = $clog2(N);
  logic         found;
  logic [W-1:0] idx;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (en && req[idx] && !found) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = idx;
      end
    end
  end
endmodule

// File: rtl/fdiv_sched.sv
// fdiv_sched: shares one pipelined fdiv between N_REQ valid/ready requesters.
//   clk, rstn            clock, asynchronous active-low reset
//   en                   1 allows new grants; in-flight ops always drain
//   req_valid/x1/x2      per-requester request; operands packed 32 bits per requester
//   req_ready            combinational one-hot round-robin grant
//   resp_valid/id/y      one-cycle result pulse with the issuing requester's id
//   inflight, busy       accepted-but-unreturned op count and its non-zero flag
module fdiv_sched
  import fpu_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int FDIV_LAT = FDIV_LAT_DEFAULT,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*32-1:0] req_x1,
  input  logic [N_REQ*32-1:0] req_x2,
  output logic [N_REQ-1:0]    req_ready,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_id,
  output fp32_t               resp_y,
  output logic [ID_W+1:0]     inflight,
  output logic                busy
);
  fp32_t           x1_a [N_REQ];
  fp32_t           x2_a [N_REQ];
  logic [ID_W-1:0] gnt_idx, rr_ptr_d, rr_ptr_q, iss_id_d, iss_id_q, resp_id_d, resp_id_q;
  logic            hs, iss_v_d, iss_v_q, resp_valid_d, resp_valid_q;
  fp32_t           iss_x1_d, iss_x1_q, iss_x2_d, iss_x2_q, resp_y_d, resp_y_q, fdiv_y;
  logic [ID_W+1:0] inflight_d, inflight_q;
  div_tag_t        tag_d [FDIV_LAT];
  div_tag_t        tag_q [FDIV_LAT];
  div_tag_t        tag_out;
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign x1_a[g] = req_x1[32*g +: 32];
    assign x2_a[g] = req_x2[32*g +: 32];
  end
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid),
    .en(en),
    .ptr(rr_ptr_q),
    .grant(req_ready),
    .grant_idx(gnt_idx)
  );
  fdiv #(.LAT(FDIV_LAT)) u_fdiv (
    .clk(clk),
    .x1(iss_x1_q),
    .x2(iss_x2_q),
    .y(fdiv_y)
  );
  // a grant is only ever given to a valid requester, so any grant is a handshake
  assign hs = |req_ready;
  assign tag_out = tag_q[FDIV_LAT-1];
  always_comb begin
    rr_ptr_d = hs ? gnt_idx : rr_ptr_q;
    iss_v_d = hs;
    iss_id_d = hs ? gnt_idx : iss_id_q;
    iss_x1_d = hs ? x1_a[gnt_idx] : iss_x1_q;
    iss_x2_d = hs ? x2_a[gnt_idx] : iss_x2_q;
    // the tag leaves the pipe on the same edge fdiv presents the matching quotient
    tag_d[0] = '{v: iss_v_q, id: ID_W_MAX'(iss_id_q)};
    for (int i = 1; i < FDIV_LAT; i++) tag_d[i] = tag_q[i-1];
    resp_valid_d = tag_out.v;
    resp_id_d = tag_out.v ? ID_W'(tag_out.id) : resp_id_q;
    resp_y_d = tag_out.v ? fdiv_y : resp_y_q;
    // an op stops counting on the edge that raises its resp_valid
    inflight_d = inflight_q + (ID_W+2)'(hs) - (ID_W+2)'(tag_out.v);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= ID_W'(N_REQ - 1);
      iss_v_q <= 1'b0;
      iss_id_q <= '0;
      iss_x1_q <= '0;
      iss_x2_q <= '0;
      tag_q <= '{default: '0};
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_y_q <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      iss_v_q <= iss_v_d;
      iss_id_q <= iss_id_d;
      iss_x1_q <= iss_x1_d;
      iss_x2_q <= iss_x2_d;
      tag_q <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_y_q <= resp_y_d;
      inflight_q <= inflight_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_y = resp_y_q;
  assign inflight = inflight_q;
  assign busy = inflight_q != '0;
endmodule

// File: tb/tb_fdiv_sched.sv
// tb_fdiv_sched: self-checking bench for fdiv_sched (N_REQ=4, FDIV_LAT=2).
module tb_fdiv_sched;
  localparam int N = 4;
  localparam int L = 2;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*32-1:0] req_x1 = '0;
  logic [N*32-1:0] req_x2 = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [31:0]    resp_y;
  logic [3:0]     inflight;
  logic           busy;

  fdiv_sched #(.N_REQ(N), .FDIV_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .en(en), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [31:0] y; int due;} op_t;
  typedef struct {logic [31:0] x1; logic [31:0] x2; logic [31:0] y;} vec_t;
  op_t         q[$];
  vec_t        tbl[8];
  logic [31:0] exp_y[N];
  int          last = N - 1;
  int          cyc = 0;
  int          granted = -1;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // real-number reference; operands and results are always normal numbers
  function automatic real f2r(logic [31:0] f);
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [10:0] e;
    d = $realtobits(r);
    m = {2'b01, d[51:29]};
    m = m + 25'(d[28] & ((|d[27:0]) | d[29]));
    e = d[62:52] - 11'd896 + 11'(m[24]);
    return {d[63], e[7:0], m[24] ? 23'd0 : m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // round robin as described: first valid index after the last grant
  function automatic int pick();
    if (!en) return -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_req(int k, logic [31:0] a, logic [31:0] b, logic [31:0] y);
    req_valid[k] = 1'b1;
    req_x1[32*k +: 32] = a;
    req_x2[32*k +: 32] = b;
    exp_y[k] = y;
  endtask

  // one clock: check grant, advance the model, check the response side
  task automatic step();
    int g;
    #1;
    g = pick();
    chk("ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1) << g);
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      q.push_back('{id: g, y: exp_y[g], due: cyc + L + 1});
      last = g;
    end
    granted = g;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
      chk("resp_y", resp_y, q[0].y);
      void'(q.pop_front());
    end else begin
      chk("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * L + 4 && q.size() > 0; i++) step();
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{32'h40400000, 32'h40000000, 32'h3fc00000};
    tbl[1] = '{32'h437f0000, 32'hc37f0000, 32'hbf800000};
    tbl[2] = '{32'h40200000, 32'h40000000, 32'h3fa00000};
    tbl[3] = '{32'h4048f5c3, 32'h40000000, 32'h3fc8f5c3};
    tbl[4] = '{32'h3f800000, 32'h40400000, 32'h3eaaaaab};
    tbl[5] = '{32'h7f000000, 32'h3e800000, 32'h7f800000};
    tbl[6] = '{32'h00000000, 32'h3f800000, 32'h00000000};
    tbl[7] = '{32'h3f800000, 32'h00000000, 32'h7f800000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rstn = 1'b1;

    // T3: all requesters valid -> strict rotation from index 0
    set_req(0, tbl[0].x1, tbl[0].x2, tbl[0].y);
    for (int k = 1; k < N; k++) set_req(k, tbl[k].x1, tbl[k].x2, tbl[k].y);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_rotation", 32'(req_ready), 32'(1) << (i % N));
      step();
    end

    // T4: drop en with a full pipe; pending results still emerge
    en = 1'b0;
    #1;
    chk("t4_inflight_full", 32'(inflight), L + 1);
    cnt = 0;
    for (int i = 0; i < L + 4; i++) begin
      step();
      cnt += int'(resp_valid);
    end
    chk("t4_drained_count", 32'(cnt), L + 1);
    chk("t4_busy", 32'(busy), 32'd0);
    req_valid = '0;
    en = 1'b1;

    // T2 and table vectors: one isolated op each, checked on its pulse cycle
    for (int r = 0; r < 8; r++) begin
      set_req(r % N, tbl[r].x1, tbl[r].x2, tbl[r].y);
      step();
      req_valid = '0;
      for (int i = 0; i < L + 1; i++) step();
      chk("tbl_valid", 32'(resp_valid), 32'd1);
      chk("tbl_y", resp_y, tbl[r].y);
      chk("tbl_id", 32'(resp_id), 32'(r % N));
    end
    drain();

    // T5: req2 alone, then req1 two cycles later
    set_req(2, tbl[2].x1, tbl[2].x2, tbl[2].y);
    #1;
    chk("t5_req2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    set_req(1, tbl[1].x1, tbl[1].x2, tbl[1].y);
    #1;
    chk("t5_req1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    drain();

    // T1: reset with three ops in flight
    for (int k = 0; k < N; k++) set_req(k, tbl[k].x1, tbl[k].x2, tbl[k].y);
    repeat (3) step();
    chk("t1_pre_inflight", 32'(inflight), 32'd3);
    #2 rstn = 1'b0;
    #1;
    q.delete();
    last = N - 1;
    req_valid = '0;
    chk("t1_resp_valid", 32'(resp_valid), 32'd0);
    chk("t1_inflight", 32'(inflight), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (L + 3) step();
    set_req(3, tbl[3].x1, tbl[3].x2, tbl[3].y);
    set_req(1, tbl[1].x1, tbl[1].x2, tbl[1].y);
    #1;
    chk("t1_first_grant", 32'(req_ready), 32'h2);
    req_valid = '0;

    // T6: random stream against the queue model
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
          logic [31:0] a, b;
          a = rnd_fp();
          b = rnd_fp();
          set_req(k, a, b, r2f(f2r(a) / f2r(b)));
        end
      end
      en = $urandom_range(0, 9) != 0;
      step();
      if (granted >= 0) req_valid[granted] = 1'b0;
    end
    req_valid = '0;
    en = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
